cmp_sequencer: RTL and testbench
================================

Name: cmp_sequencer

Overview:
Multi-cycle controller that compares two NIBBLES×4-bit operands using one shared 4-bit magnitude comparator. It works nibble by nibble from MSB to LSB and stops at the first nibble that differs. It sits between the microcontroller's execute stage, which issues compare-and-branch operations, and a single COMPARATOR instance. It drives that instance's operand and enable inputs and samples its less/equal/greater outputs. An optional signed mode compares two's-complement operands on the same unsigned comparator.

Parameters:
NIBBLES, 4, number of 4-bit nibbles per operand; operand width W = 4*NIBBLES; legal range 1..8

Ports:
i_clk  input  1  system clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_start  input  1  request a compare; accepted only while o_busy=0
i_signed  input  1  sampled with i_start; 1 = two's-complement compare
i_operand_a  input  W  first operand, sampled on the accepted start
i_operand_b  input  W  second operand, sampled on the accepted start
o_cmp_operand1  output  4  to comparator i_operand1
o_cmp_operand2  output  4  to comparator i_operand2
o_cmp_enable  output  1  to comparator i_enable
i_cmp_less  input  1  from comparator o_oper1_less_oper2
i_cmp_equal  input  1  from comparator o_oper1_equal_oper2
i_cmp_greater  input  1  from comparator o_oper1_greater_oper2
o_busy  output  1  compare in progress
o_done  output  1  one-cycle pulse: result valid
o_a_lt_b  output  1  registered result, held until the next accepted start
o_a_eq_b  output  1  registered result
o_a_gt_b  output  1  registered result
o_err  output  1  comparator returned an illegal flag pattern

Behaviour:
- Reset (async, i_rst_n=0): state IDLE. o_busy, o_done, o_a_lt_b, o_a_eq_b, o_a_gt_b, o_err, o_cmp_enable = 0. o_cmp_operand1/2 = 0. Internal nibble index = NIBBLES-1. Operand registers cleared.
- Reset mid-operation aborts the compare immediately. No o_done is produced for the aborted compare.
- States: IDLE, COMPARE, DONE.
- IDLE or DONE, with i_start=1 at a clock edge:
  - latch A, B and i_signed;
  - clear all result flags and o_err;
  - set index = NIBBLES-1;
  - go to COMPARE.
- DONE with i_start=0: go to IDLE.
- COMPARE outputs (combinational from state):
  - o_cmp_enable=1, o_busy=1;
  - o_cmp_operand1/2 = latched A/B nibble [4*idx+3 : 4*idx];
  - in signed mode, when idx = NIBBLES-1, bit 3 of both driven nibbles is inverted. This sign-bias makes the unsigned result correct for two's complement.
- COMPARE, at each edge, the comparator flags are sampled in the same cycle (the comparator is combinational):
  - exactly one of less/greater set: load o_a_lt_b/o_a_gt_b accordingly, go to DONE;
  - equal set and idx=0: set o_a_eq_b, go to DONE;
  - equal set and idx>0: idx <= idx-1, stay in COMPARE;
  - zero flags or more than one flag set: set o_err, all result flags 0, go to DONE.
- i_start while o_busy=1 is ignored; no queuing. Changes to i_operand_a/b or i_signed during COMPARE have no effect.
- DONE: o_done=1 for exactly one cycle, o_busy=0, o_cmp_enable=0.
- Outside COMPARE: o_cmp_enable=0 and o_cmp_operand1/2 = 0.
- Latency, counted from the start-accept edge:
  - k nibbles compared (1..NIBBLES) means k COMPARE cycles;
  - o_done is high in cycle k+1;
  - best case 2 cycles, worst case NIBBLES+1.
- Back-to-back: i_start while in DONE is accepted. COMPARE is re-entered in the next cycle with no IDLE bubble.
- Result flags are mutually exclusive. After reset exactly one is set per completed compare, or none with o_err=1.
- No arithmetic beyond the index decrement. The index never wraps below 0.

Test Plan:
1. Unsigned: A=0x1234, B=0x1235 -> 4 COMPARE cycles; o_done high in cycle 5; o_a_lt_b=1, eq=0, gt=0; o_cmp_operand1 sequence 1,2,3,4.
2. A=0xA000, B=0x1FFF, i_signed=0 -> 1 COMPARE cycle, o_a_gt_b=1, done in cycle 2. Same operands with i_signed=1 -> o_a_lt_b=1 and driven MSB nibbles 0x2/0x9.
3. A=B=0xBEEF -> o_a_eq_b=1 after 4 COMPARE cycles. Immediately issue a new start in the DONE cycle with A=0x0001, B=0x0000 -> o_a_gt_b=1 after 4 more cycles, with no idle cycle between the two compares.
4. Start A=0x5555, B=0x5556. In cycle 2, pulse i_start with different operands and change i_operand_a to 0xFFFF -> the second start is ignored; the result is still o_a_lt_b=1; exactly one o_done pulse.
5. Start A=0x1111, B=0x1112. Assert i_rst_n=0 asynchronously mid-cycle 2 -> all outputs 0 without waiting for a clock edge; no o_done. After release, start A=0x0003, B=0x0003 -> o_a_eq_b=1.
6. Bench forces the comparator flags to 000, then to 110, during COMPARE -> o_err=1, all result flags 0, o_done pulses once; o_err clears on the next accepted start.

Source files
------------

// File: rtl/cmp_sequencer.sv
// cmp_sequencer: compares two NIBBLES x 4-bit operands one nibble at a time,
// MSB first, through a single shared external 4-bit magnitude comparator.
// Stops at the first differing nibble. Signed mode flips the sign bit of the
// top nibble so the unsigned comparator orders two's-complement values.
module cmp_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_signed,
  input  logic [4*NIBBLES-1:0] i_operand_a,
  input  logic [4*NIBBLES-1:0] i_operand_b,
  output logic [3:0]           o_cmp_operand1,
  output logic [3:0]           o_cmp_operand2,
  output logic                 o_cmp_enable,
  input  logic                 i_cmp_less,
  input  logic                 i_cmp_equal,
  input  logic                 i_cmp_greater,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_a_lt_b,
  output logic                 o_a_eq_b,
  output logic                 o_a_gt_b,
  output logic                 o_err
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_COMPARE, S_DONE} state_t;

  state_t          r_state, w_next;
  logic [W-1:0]    r_a, r_b;
  logic            r_signed;
  logic [IW-1:0]   r_idx;
  logic            r_lt, r_eq, r_gt, r_err;

  logic            w_accept;
  logic [2:0]      w_flags;
  logic            w_is_lt, w_is_eq, w_is_gt;
  logic            w_bias;
  logic [3:0]      w_nib_a, w_nib_b;

  // New compares are only taken when no compare is in flight.
  assign w_accept = i_start && (r_state != S_COMPARE);
  assign w_flags  = {i_cmp_less, i_cmp_equal, i_cmp_greater};
  assign w_is_lt  = (w_flags == 3'b100);
  assign w_is_eq  = (w_flags == 3'b010);
  assign w_is_gt  = (w_flags == 3'b001);
  assign w_bias   = r_signed && (r_idx == IDX_TOP);

  // State register; reset aborts any compare in flight.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  // Next-state: leave COMPARE on a decisive, final-equal or illegal flag set.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_next = S_COMPARE;
      S_COMPARE: begin
        if (w_is_lt || w_is_gt)           w_next = S_DONE;
        else if (w_is_eq && r_idx != '0)  w_next = S_COMPARE;
        else                              w_next = S_DONE;
      end
      S_DONE:    w_next = w_accept ? S_COMPARE : S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Select the current nibble of each latched operand.
  always_comb begin
    w_nib_a = '0;
    w_nib_b = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IW'(n)) begin
        w_nib_a = r_a[4*n +: 4];
        w_nib_b = r_b[4*n +: 4];
      end
    end
  end

  // Comparator drive and status, decoded from state only.
  always_comb begin
    o_cmp_enable   = (r_state == S_COMPARE);
    o_busy         = (r_state == S_COMPARE);
    o_done         = (r_state == S_DONE);
    o_cmp_operand1 = '0;
    o_cmp_operand2 = '0;
    if (r_state == S_COMPARE) begin
      o_cmp_operand1 = w_nib_a ^ {w_bias, 3'b000};
      o_cmp_operand2 = w_nib_b ^ {w_bias, 3'b000};
    end
  end

  // Operand latch, nibble index and result flags.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_a      <= '0;
      r_b      <= '0;
      r_signed <= 1'b0;
      r_idx    <= IDX_TOP;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_err    <= 1'b0;
    end else if (w_accept) begin
      r_a      <= i_operand_a;
      r_b      <= i_operand_b;
      r_signed <= i_signed;
      r_idx    <= IDX_TOP;
      r_lt     <= 1'b0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_err    <= 1'b0;
    end else if (r_state == S_COMPARE) begin
      if (w_is_lt)                     r_lt  <= 1'b1;
      else if (w_is_gt)                r_gt  <= 1'b1;
      else if (w_is_eq && r_idx == '0) r_eq  <= 1'b1;
      else if (w_is_eq)                r_idx <= r_idx - IW'(1);
      else begin
        r_err <= 1'b1;
        r_lt  <= 1'b0;
        r_eq  <= 1'b0;
        r_gt  <= 1'b0;
      end
    end
  end

  assign o_a_lt_b = r_lt;
  assign o_a_eq_b = r_eq;
  assign o_a_gt_b = r_gt;
  assign o_err    = r_err;

endmodule

// File: tb/tb_cmp_sequencer.sv
// tb_cmp_sequencer: directed stimulus with a scoreboard queue of expected
// results; a monitor pops and checks whenever o_done pulses.
module tb_cmp_sequencer;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sgn = 1'b0;
  logic [W-1:0] opa = '0, opb = '0;
  logic [3:0]   op1, op2;
  logic         en, less, equal, greater;
  logic         busy, done, lt, eq, gt, err;

  int           cyc = 0;
  int           n_chk = 0;
  int           n_fail = 0;
  int           f_mode = 0;   // 0: real comparator, 1: flags 000, 2: flags 110

  typedef struct {
    logic [3:0] flags;        // {lt, eq, gt, err}
    int         cyc;
  } exp_t;
  exp_t q[$];

  cmp_sequencer #(.NIBBLES(NIBBLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_signed(sgn),
    .i_operand_a(opa), .i_operand_b(opb),
    .o_cmp_operand1(op1), .o_cmp_operand2(op2), .o_cmp_enable(en),
    .i_cmp_less(less), .i_cmp_equal(equal), .i_cmp_greater(greater),
    .o_busy(busy), .o_done(done), .o_a_lt_b(lt), .o_a_eq_b(eq),
    .o_a_gt_b(gt), .o_err(err)
  );

  // Behavioural comparator with fault injection.
  always_comb begin
    {less, equal, greater} = 3'b000;
    if (f_mode == 1)      {less, equal, greater} = 3'b000;
    else if (f_mode == 2) {less, equal, greater} = 3'b110;
    else if (en)          {less, equal, greater} = {op1 < op2, op1 == op2, op1 > op2};
  end

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest expected result.
  always @(negedge clk) begin
    if (rst_n && done) begin
      check("done_expected", 32'(q.size() != 0), 1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("result_flags", {28'd0, lt, eq, gt, err}, {28'd0, e.flags});
        check("done_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic do_start(input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s, output int c0);
    @(negedge clk);
    start = 1'b1; opa = a; opb = b; sgn = s;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
  endtask

  task automatic push(input logic [3:0] flags, input int k, input int c0);
    exp_t e;
    e.flags = flags;
    e.cyc   = c0 + k;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && !done) return;
    end
    check("idle_timeout", {30'd0, busy, done}, 0);
  endtask

  initial begin
    int c0;
    repeat (2) @(negedge clk);
    check("reset_outputs", {busy, done, lt, eq, gt, err, en, op1, op2}, 0);
    rst_n = 1'b1;

    // 1: unsigned less, 4 nibbles, operand1 walks 1,2,3,4
    do_start(16'h1234, 16'h1235, 1'b0, c0);
    push(4'b1000, 4, c0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t1_operand1", {28'd0, op1}, i + 1);
    end
    wait_idle();
    check("t1_result_held", {29'd0, lt, eq, gt}, 32'b100);

    // 2: MSB decides; signed mode flips the ordering
    do_start(16'hA000, 16'h1FFF, 1'b0, c0);
    push(4'b0010, 1, c0);
    @(negedge clk);
    check("t2_unsigned_nibbles", {24'd0, op1, op2}, 32'hA1);
    wait_idle();
    do_start(16'hA000, 16'h1FFF, 1'b1, c0);
    push(4'b1000, 1, c0);
    @(negedge clk);
    check("t2_signed_nibbles", {24'd0, op1, op2}, 32'h29);
    wait_idle();

    // 3: equal, then back-to-back start issued in the DONE cycle
    do_start(16'hBEEF, 16'hBEEF, 1'b0, c0);
    push(4'b0100, 4, c0);
    repeat (4) @(negedge clk);
    do_start(16'h0001, 16'h0000, 1'b0, c0);
    push(4'b0010, 4, c0);
    @(negedge clk);
    check("t3_no_bubble_busy", {31'd0, busy}, 1);
    wait_idle();

    // 4: start during COMPARE ignored, operand change ignored
    do_start(16'h5555, 16'h5556, 1'b0, c0);
    push(4'b1000, 4, c0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; opa = 16'hFFFF; opb = 16'h0000; sgn = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("t4_operand_unchanged", {24'd0, op1, op2}, 32'h55);
    wait_idle();

    // 5: async reset mid-compare, no done; then a clean equal compare
    do_start(16'h1111, 16'h1112, 1'b0, c0);
    @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_reset", {busy, done, lt, eq, gt, err, en, op1, op2}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(16'h0003, 16'h0003, 1'b0, c0);
    push(4'b0100, 4, c0);
    wait_idle();

    // 6: illegal comparator flags, then err clears on the next start
    f_mode = 1;
    do_start(16'h1234, 16'h1234, 1'b0, c0);
    push(4'b0001, 1, c0);
    wait_idle();
    check("t6_err_held", {28'd0, lt, eq, gt, err}, 32'b0001);
    f_mode = 2;
    do_start(16'h1234, 16'h1234, 1'b0, c0);
    push(4'b0001, 1, c0);
    wait_idle();
    f_mode = 0;
    do_start(16'h0002, 16'h0001, 1'b0, c0);
    push(4'b0010, 4, c0);
    @(negedge clk);
    check("t6_err_cleared", {31'd0, err}, 0);
    wait_idle();

    repeat (5) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
